// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared state encoding and line-level constants for the
// serial transmit controller.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: counts 0..CLKS_PER_BIT-1 and wraps, flagging the last clock of
// each bit period with a one-cycle wrap pulse. A held clear parks it at zero.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clear,
  output logic o_wrap
);

  localparam int CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] r_count;
  logic            w_atLast;

  assign w_atLast = (r_count == LastCnt);
  assign o_wrap   = !i_clear && w_atLast;

  // Bit-period counter: restarts on clear or after the last clock of a bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (i_clear || w_atLast) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx_ctrl.sv
// serial_tx_ctrl: framed serial transmitter (start, DATA_BITS LSB first,
// optional even parity, STOP_BITS stop bits). Define SERIAL_TX_PARITY_EN to
// insert the parity bit; without it the PARITY state and its logic are absent.
// serial_out is registered from the current state, so the start bit appears
// one edge after the handshake is accepted.
module serial_tx_ctrl #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  import serial_tx_pkg::*;

  localparam int IdxW = $clog2(DATA_BITS + 1);
  localparam logic [IdxW-1:0] LastDataIdx = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] LastStopIdx = IdxW'(STOP_BITS - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [DATA_BITS-1:0] r_shifter;
  logic [IdxW-1:0]      r_bitIdx;
  logic                 r_serialOut;
  logic                 r_frameDone;
  logic                 w_wrap;
  logic                 w_timerClear;
  logic                 w_accept;
  logic                 w_shift;
  logic                 w_advanceIdx;
  logic                 w_lineLevel;
  logic                 w_frameEnd;
`ifdef SERIAL_TX_PARITY_EN
  logic                 r_parity;
`endif

  // The timer only runs while a frame is in progress.
  assign w_timerClear = (r_state == IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitTimer (
    .clk    (clk),
    .n_rst  (n_rst),
    .i_clear(w_timerClear),
    .o_wrap (w_wrap)
  );

  assign tx_ready   = (r_state == IDLE);
  assign tx_busy    = (r_state != IDLE);
  assign serial_out = r_serialOut;
  assign frame_done = r_frameDone;
  assign w_frameEnd = (r_state == STOP) && (w_nextState == IDLE);

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode, line level and shifter/index control per state.
  always_comb begin
    w_nextState  = r_state;
    w_lineLevel  = LINE_IDLE;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    w_advanceIdx = 1'b0;
    case (r_state)
      IDLE: begin
        if (tx_valid) begin
          w_accept    = 1'b1;
          w_nextState = START;
        end
      end
      START: begin
        w_lineLevel = LINE_START;
        if (w_wrap) begin
          w_nextState = DATA;
        end
      end
      DATA: begin
        w_lineLevel = r_shifter[0];
        if (w_wrap) begin
          w_shift = 1'b1;
          if (r_bitIdx == LastDataIdx) begin
`ifdef SERIAL_TX_PARITY_EN
            w_nextState = PARITY;
`else
            w_nextState = STOP;
`endif
          end else begin
            w_advanceIdx = 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        w_lineLevel = r_parity;
        if (w_wrap) begin
          w_nextState = STOP;
        end
      end
`endif
      STOP: begin
        w_lineLevel = LINE_IDLE;
        if (w_wrap) begin
          if (r_bitIdx == LastStopIdx) begin
            w_nextState = IDLE;
          end else begin
            w_advanceIdx = 1'b1;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: registered line, done pulse, captured word and bit index.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_serialOut <= LINE_IDLE;
      r_frameDone <= 1'b0;
      r_shifter   <= '1;
      r_bitIdx    <= '0;
    end else begin
      r_serialOut <= w_lineLevel;
      r_frameDone <= w_frameEnd;
      if (w_accept) begin
        r_shifter <= tx_data;
      end else if (w_shift) begin
        r_shifter <= {1'b1, r_shifter[DATA_BITS-1:1]};
      end
      if (r_state != w_nextState) begin
        r_bitIdx <= '0;
      end else if (w_advanceIdx) begin
        r_bitIdx <= r_bitIdx + 1'b1;
      end
    end
  end

`ifdef SERIAL_TX_PARITY_EN
  // Even parity of the word, latched at capture so later input changes are ignored.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_parity <= 1'b0;
    end else if (w_accept) begin
      r_parity <= ^tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_serial_tx_ctrl.sv
// tb_serial_tx_ctrl: table vectors, hand-written corner sequences and random
// traffic against a frame-level reference model of the serial line.
module tb_serial_tx_ctrl;

  localparam int DB   = 8;
  localparam int CPB  = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P    = 1;
`else
  localparam int P    = 0;
`endif
  localparam int NB1  = 1 + DB + P + 1;
  localparam int NB2  = 1 + DB + P + 2;
  localparam int F1   = NB1 * CPB;
  localparam int F2   = NB2 * CPB;
  localparam int MAXS = 8192;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frameBits;
    logic       parity;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady, serialOut, txBusy, frameDone;
  logic [7:0] tx2Data = 8'h00;
  logic       tx2Valid = 1'b0;
  logic       tx2Ready, serial2Out, tx2Busy, frame2Done;

  int  vectors = 0;
  int  miscompares = 0;
  int  edgeIdx = 0;
  int  freeAt = 0;
  bit  expLine [MAXS];
  bit  expDone [MAXS];
  bit  monOn = 1'b0;
  logic expReady;

  serial_tx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk(clk), .n_rst(n_rst), .tx_data(txData), .tx_valid(txValid),
    .tx_ready(txReady), .serial_out(serialOut), .tx_busy(txBusy), .frame_done(frameDone)
  );

  serial_tx_ctrl #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .tx_data(tx2Data), .tx_valid(tx2Valid),
    .tx_ready(tx2Ready), .serial_out(serial2Out), .tx_busy(tx2Busy), .frame_done(frame2Done)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop if anything stalls far beyond the expected run length.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at sample %0d: got %b, required %b", name, edgeIdx, act, exp);
    end
  endtask

  // Frame bit j of a word: start, data LSB first, optional even parity, then stop ones.
  function automatic logic frameBit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j <= DB) return d[j-1];
    if (P == 1 && j == DB + 1) return ^d;
    return 1'b1;
  endfunction

  // Reference model: on an accepted word, schedule the whole line waveform and done pulse.
  always @(posedge clk) begin
    edgeIdx++;
    if (n_rst && txValid && (edgeIdx - 1 >= freeAt)) begin
      for (int t = 1; t <= F1; t++) begin
        if (edgeIdx + t < MAXS) expLine[edgeIdx + t] = frameBit(txData, (t - 1) / CPB);
      end
      if (edgeIdx + F1 < MAXS) expDone[edgeIdx + F1] = 1'b1;
      freeAt = edgeIdx + F1;
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (monOn && edgeIdx < MAXS) begin
      expReady = (!n_rst) || (edgeIdx >= freeAt);
      checkOutput("line", serialOut, expLine[edgeIdx]);
      checkOutput("frame_done", frameDone, expDone[edgeIdx]);
      checkOutput("tx_ready", txReady, expReady);
      checkOutput("tx_busy", txBusy, !expReady);
    end
  end

  task automatic modelReset();
    for (int s = edgeIdx + 1; s < MAXS; s++) begin
      expLine[s] = 1'b1;
      expDone[s] = 1'b0;
    end
    freeAt = 0;
  endtask

  task automatic waitIdle();
    for (int w = 0; w < 200 && edgeIdx < freeAt; w++) @(negedge clk);
    checkOutput("ready_before_send", txReady, 1'b1);
  endtask

  task automatic applyStimulus(input vec_t v);
    int   k;
    logic expBit;
    waitIdle();
    txData  = v.data;
    txValid = 1'b1;
    @(negedge clk);
    k = edgeIdx;
    txValid = 1'b0;
    txData  = ~v.data;
    for (int b = 0; b < NB1; b++) begin
      while (edgeIdx < k + b * CPB + 2) @(negedge clk);
      if (b <= DB) expBit = v.frameBits[b];
      else if (P == 1 && b == DB + 1) expBit = v.parity;
      else expBit = 1'b1;
      checkOutput($sformatf("bit%0d_of_%02h", b, v.data), serialOut, expBit);
    end
    while (edgeIdx < k + F1 - 1) @(negedge clk);
    checkOutput("done_early", frameDone, 1'b0);
    @(negedge clk);
    checkOutput("done_pulse", frameDone, 1'b1);
    checkOutput("ready_at_done", txReady, 1'b1);
    checkOutput("busy_at_done", txBusy, 1'b0);
  endtask

  initial begin
    vec_t vecs [7];
    int   k;
    logic doneSeen;
    logic expBit;
    vecs[0] = '{8'hA5, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h01, 10'b1000000010, 1'b1};
    vecs[2] = '{8'h00, 10'b1000000000, 1'b0};
    vecs[3] = '{8'hFF, 10'b1111111110, 1'b0};
    vecs[4] = '{8'h3C, 10'b1001111000, 1'b0};
    vecs[5] = '{8'h5A, 10'b1010110100, 1'b0};
    vecs[6] = '{8'h80, 10'b1100000000, 1'b1};
    for (int s = 0; s < MAXS; s++) begin
      expLine[s] = 1'b1;
      expDone[s] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_line", serialOut, 1'b1);
    checkOutput("rst_ready", txReady, 1'b1);
    checkOutput("rst_busy", txBusy, 1'b0);
    checkOutput("rst_done", frameDone, 1'b0);
    monOn = 1'b1;
    n_rst = 1'b1;
    @(negedge clk);

    // Table of single frames
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    // Back-to-back with tx_valid held high
    waitIdle();
    txData  = 8'h00;
    txValid = 1'b1;
    @(negedge clk);
    k = edgeIdx;
    txData = 8'hFF;
    while (edgeIdx < k + F1) @(negedge clk);
    checkOutput("b2b_done", frameDone, 1'b1);
    checkOutput("b2b_ready", txReady, 1'b1);
    @(negedge clk);
    checkOutput("b2b_gap_high", serialOut, 1'b1);
    txValid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_start2", serialOut, 1'b0);
    checkOutput("b2b_busy2", txBusy, 1'b1);

    // tx_valid pulsed mid-frame must be ignored
    waitIdle();
    txData  = 8'hA5;
    txValid = 1'b1;
    @(negedge clk);
    k = edgeIdx;
    txValid = 1'b0;
    while (edgeIdx < k + 12) @(negedge clk);
    txData  = 8'h3C;
    txValid = 1'b1;
    checkOutput("gate_ready", txReady, 1'b0);
    @(negedge clk);
    txValid = 1'b0;
    checkOutput("gate_busy", txBusy, 1'b1);
    while (edgeIdx < k + F1) @(negedge clk);
    checkOutput("gate_done", frameDone, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("gate_idle_line", serialOut, 1'b1);
    checkOutput("gate_idle_busy", txBusy, 1'b0);

    // Reset during data bit 3 aborts the frame
    waitIdle();
    txData  = 8'h00;
    txValid = 1'b1;
    @(negedge clk);
    k = edgeIdx;
    txValid = 1'b0;
    while (edgeIdx < k + 4 * CPB + 2) @(negedge clk);
    checkOutput("pre_rst_line", serialOut, 1'b0);
    #1;
    n_rst = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_async_line", serialOut, 1'b1);
    checkOutput("rst_async_ready", txReady, 1'b1);
    checkOutput("rst_async_busy", txBusy, 1'b0);
    checkOutput("rst_async_done", frameDone, 1'b0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    doneSeen = 1'b0;
    for (int c = 0; c < F1 + 5; c++) begin
      @(negedge clk);
      doneSeen = doneSeen | frameDone;
    end
    checkOutput("no_done_after_abort", doneSeen, 1'b0);
    applyStimulus(vecs[5]);

    // Random traffic, including valid pulses while busy
    for (int c = 0; c < 1500; c++) begin
      txValid = ($urandom_range(0, 3) == 0);
      txData  = 8'($urandom);
      @(negedge clk);
    end
    txValid = 1'b0;
    waitIdle();
    @(negedge clk);

    // Two stop bits on the second instance: 0x81
    tx2Data  = 8'h81;
    tx2Valid = 1'b1;
    @(negedge clk);
    k = edgeIdx;
    tx2Valid = 1'b0;
    for (int t = 1; t <= F2; t++) begin
      while (edgeIdx < k + t) @(negedge clk);
      if ((t - 1) / CPB <= DB) expBit = vecs[6].frameBits[(t - 1) / CPB] | ((t - 1) / CPB == 1);
      else expBit = 1'b1;
      checkOutput($sformatf("stop2_line_t%0d", t), serial2Out, expBit);
      if (t == F2 - 1) begin
        checkOutput("stop2_done_early", frame2Done, 1'b0);
        checkOutput("stop2_busy", tx2Busy, 1'b1);
      end
    end
    checkOutput("stop2_done", frame2Done, 1'b1);
    checkOutput("stop2_ready", tx2Ready, 1'b1);

    monOn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
